i281_fetch_unit: RTL and testbench
==================================

Name: i281_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the i281 opcode decoder.
- Owns the program counter and issues word reads to instruction memory over a req/valid handshake.
- Latches the 16-bit instruction into the IR and presents IR[15:8] as the 8-bit opcode field and IR[7:0] as the immediate/offset byte to downstream stages.
- Applies the jump/branch redirect returned by execute when the instruction retires.

Parameters:
- PC_W, 6: program counter width; instruction memory depth is 2^PC_W words.
- INSTR_W, 16: instruction word width; fixed at 16 for i281.
- WAIT_MAX, 15: cycles in WAIT without imem_valid before a fetch fault is raised.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run_en  in  1  level; permits new fetches.
- imem_req  out  1  one-cycle read request.
- imem_addr  out  PC_W  read address; equals pc while imem_req is high.
- imem_valid  in  1  read data valid.
- imem_rdata  in  INSTR_W  instruction word.
- opcode_field  out  8  IR[15:8], feeds the opcode decoder.
- imm_field  out  8  IR[7:0].
- ir_valid  out  1  IR holds an instruction not yet retired.
- ex_ready  in  1  downstream retires the IR this cycle.
- br_taken  in  1  redirect request, qualified by ex_ready.
- br_offset  in  8  signed two's-complement offset.
- pc  out  PC_W  address of the instruction in the IR.
- fetch_fault  out  1  sticky; set on WAIT timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, pc=0, IR=16'h0000 (decodes as NOOP), ir_valid=0, imem_req=0, imem_addr=0, fetch_fault=0, wait counter=0.
- State IDLE: if run_en=1 and fetch_fault=0, go to REQ.
- State REQ: imem_req=1 for exactly one cycle, imem_addr=pc; go to WAIT; clear the wait counter.
- State WAIT:
  - If imem_valid=1: load IR<=imem_rdata, ir_valid<=1, go to HOLD.
  - Otherwise increment the counter. When the counter reaches WAIT_MAX: set fetch_fault, go to IDLE, IR unchanged.
  - imem_valid in any state other than WAIT is ignored.
- State HOLD: ir_valid=1 and the IR is stable. When ex_ready=1:
  - ir_valid<=0.
  - pc<=pc+1+sext(br_offset) if br_taken, else pc+1. All arithmetic is modulo 2^PC_W; wrap-around is silent (e.g. pc=63, +1 gives 0).
  - If run_en=1, go to REQ; otherwise go to IDLE.
- br_taken/br_offset are sampled only on an ex_ready cycle in HOLD; otherwise ignored.
- Latency: run_en rises in cycle 0 → REQ in cycle 1 → imem_valid no earlier than cycle 2 → ir_valid=1 in cycle 3 at the earliest. Best-case throughput is one instruction per 3 cycles.
- run_en dropped during REQ or WAIT: the outstanding fetch completes into HOLD, then the unit stops in IDLE after retire.
- fetch_fault is sticky; it is cleared only by rst_n. While it is set, no new requests are issued.
- Reset mid-WAIT: all state returns to reset values immediately; a late imem_valid is ignored because the state is IDLE.
- imem_addr holds its last value outside REQ.

Optional Feature:
- Macro: I281_SINGLE_STEP_EN.
- Defined: adds input step (1 bit). IDLE→REQ additionally requires a rising edge of step (registered edge detect); run_en still gates it. After each retire in HOLD the unit returns to IDLE regardless of run_en.
- Undefined: the step port is absent and behaviour is exactly as above.

Decomposition:
- Package i281_pkg: fetch state enum (IDLE, REQ, WAIT, HOLD), INSTR_W, the NOOP encoding 16'h0000, and the opcode field slice constants (bits 15:8, 7:0).
- Sub-module i281_pc_next: combinational next-PC adder (pc, br_taken, br_offset → next pc). It is shared with the verification model.

Test Plan:
- Reset then run_en=1, memory returns 16'h5A03 on the first WAIT cycle → imem_req in cycle 1 with addr 0; opcode_field=8'h5A, imm_field=8'h03, ir_valid=1 in cycle 3.
- pc=10, retire with br_taken=1, br_offset=8'hFC → next imem_addr=7. Same with br_offset=8'h05 → 16.
- pc=63, retire with br_taken=0 → next imem_addr=0 (wrap).
- No imem_valid for WAIT_MAX cycles → fetch_fault=1, state IDLE, no further imem_req even with run_en=1, until reset.
- run_en dropped during WAIT, imem_valid arrives → instruction latched; after ex_ready, ir_valid=0 and no new imem_req.
- rst_n asserted in WAIT, imem_valid pulses the following cycle → IR stays 16'h0000, ir_valid=0, pc=0.

Source files
------------

// File: rtl/i281_pkg.sv
// i281_pkg: shared definitions for the i281 fetch stage.
//   - fetch_state_e : fetch FSM states (IDLE, REQ, WAIT, HOLD)
//   - INSTR_W       : instruction word width (16 for i281)
//   - NOOP          : instruction encoding loaded into the IR at reset
//   - OPC_HI/OPC_LO : IR slice carrying the opcode field
//   - IMM_HI/IMM_LO : IR slice carrying the immediate/offset byte
package i281_pkg;

  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOOP = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/i281_pc_next.sv
// i281_pc_next: combinational next-PC computation.
//   pc        in  PC_W  current program counter
//   br_taken  in  1     select branch target instead of sequential pc+1
//   br_offset in  8     signed two's-complement offset, relative to pc+1
//   next_pc   out PC_W  pc+1 or pc+1+sext(br_offset), modulo 2^PC_W
module i281_pc_next #(
  parameter int PC_W = 6
) (
  input  logic [PC_W-1:0] pc,
  input  logic            br_taken,
  input  logic [7:0]      br_offset,
  output logic [PC_W-1:0] next_pc
);

  // Work in a width that holds both the PC and the full offset so the
  // sign extension is exact; truncating the sum gives the modulo wrap.
  localparam int SW = (PC_W > 8) ? PC_W : 8;

  logic [SW-1:0] pc_ext;
  logic [SW-1:0] off_ext;
  logic [SW-1:0] sum;

  always_comb begin
    pc_ext  = SW'(pc);
    off_ext = br_taken ? SW'($signed(br_offset)) : '0;
    sum     = pc_ext + SW'(1) + off_ext;
    next_pc = sum[PC_W-1:0];
  end

endmodule

// File: rtl/i281_fetch_unit.sv
// i281_fetch_unit: instruction fetch stage feeding the i281 opcode decoder.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   run_en        level; permits new fetches
//   imem_req      one-cycle read request to instruction memory
//   imem_addr     read address (equals pc while imem_req is high, holds otherwise)
//   imem_valid    read data valid (only honoured in WAIT)
//   imem_rdata    instruction word
//   opcode_field  IR[15:8]
//   imm_field     IR[7:0]
//   ir_valid      IR holds an instruction not yet retired
//   ex_ready      downstream retires the IR this cycle
//   br_taken      redirect request, qualified by ex_ready in HOLD
//   br_offset     signed redirect offset relative to pc+1
//   pc            address of the instruction in the IR
//   fetch_fault   sticky WAIT-timeout flag, cleared only by rst_n
//   fetch_state   current FSM state, for debug/observation
//   step          (only with I281_SINGLE_STEP_EN) each rising edge allows one fetch
//
// Build option: define I281_SINGLE_STEP_EN to add the step input. Fetches
// then start only on a rising edge of step (still gated by run_en), and the
// unit always returns to IDLE after each retire.
//
// Handshakes: imem_req is a single-cycle pulse; the memory answers with a
// single-cycle imem_valid at any later WAIT cycle. Downstream sees ir_valid
// held high with a stable IR until it pulses ex_ready, which retires the
// instruction in that same cycle (ex_ready acts as the ready of the
// ir_valid/ex_ready pair).
module i281_fetch_unit #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = i281_pkg::INSTR_W,
  parameter int WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run_en,
`ifdef I281_SINGLE_STEP_EN
  input  logic                   step,
`endif
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_W-1:0]     imem_rdata,
  output logic [7:0]             opcode_field,
  output logic [7:0]             imm_field,
  output logic                   ir_valid,
  input  logic                   ex_ready,
  input  logic                   br_taken,
  input  logic [7:0]             br_offset,
  output logic [PC_W-1:0]        pc,
  output logic                   fetch_fault,
  output i281_pkg::fetch_state_e fetch_state
);

  import i281_pkg::*;

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] ir_q;
  logic               ir_valid_q;
  logic               imem_req_q;
  logic [PC_W-1:0]    imem_addr_q;
  logic               fault_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               start_ok;
  logic               continue_ok;

  i281_pc_next #(
    .PC_W (PC_W)
  ) u_pc_next (
    .pc        (pc_q),
    .br_taken  (br_taken),
    .br_offset (br_offset),
    .next_pc   (pc_nxt)
  );

`ifdef I281_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  always_comb begin
    start_ok    = run_en & ~fault_q & step & ~step_q;
    continue_ok = 1'b0;
  end
`else
  always_comb begin
    start_ok    = run_en & ~fault_q;
    continue_ok = run_en;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= NOOP;
      ir_valid_q  <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      fault_q     <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      imem_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
          end
        end
        REQ: begin
          state_q    <= WAIT;
          wait_cnt_q <= '0;
        end
        WAIT: begin
          if (imem_valid) begin
            ir_q       <= imem_rdata;
            ir_valid_q <= 1'b1;
            state_q    <= HOLD;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            // This cycle's increment brings the count to WAIT_MAX.
            if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
              fault_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (ex_ready) begin
            ir_valid_q <= 1'b0;
            pc_q       <= pc_nxt;
            if (continue_ok) begin
              // Request the redirected/sequential address directly so the
              // next fetch starts without an IDLE bubble.
              state_q     <= REQ;
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc_nxt;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req     = imem_req_q;
    imem_addr    = imem_addr_q;
    opcode_field = ir_q[OPC_HI:OPC_LO];
    imm_field    = ir_q[IMM_HI:IMM_LO];
    ir_valid     = ir_valid_q;
    pc           = pc_q;
    fetch_fault  = fault_q;
    fetch_state  = state_q;
  end

endmodule

// File: tb/tb_i281_fetch_unit.sv
module tb_i281_fetch_unit;
  import i281_pkg::*;

  localparam int PC_W     = 6;
  localparam int WAIT_MAX = 15;

  logic            clk;
  logic            rst_n;
  logic            run_en;
`ifdef I281_SINGLE_STEP_EN
  logic            step;
`endif
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [15:0]     imem_rdata;
  logic [7:0]      opcode_field;
  logic [7:0]      imm_field;
  logic            ir_valid;
  logic            ex_ready;
  logic            br_taken;
  logic [7:0]      br_offset;
  logic [PC_W-1:0] pc;
  logic            fetch_fault;
  fetch_state_e    fetch_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_pc   = 0;
  logic [15:0] exp_q[$];

  i281_fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (16),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_en       (run_en),
`ifdef I281_SINGLE_STEP_EN
    .step         (step),
`endif
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .opcode_field (opcode_field),
    .imm_field    (imm_field),
    .ir_valid     (ir_valid),
    .ex_ready     (ex_ready),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .pc           (pc),
    .fetch_fault  (fetch_fault),
    .fetch_state  (fetch_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference next-PC: pc+1 (+ signed offset when taken), modulo 64.
  function automatic int model_next(input int cur, input bit taken, input logic [7:0] off);
    int o;
    o = taken ? int'($signed(off)) : 0;
    return (cur + 1 + o) & ((1 << PC_W) - 1);
  endfunction

  // Drivers
  task automatic tick();
    @(negedge clk);
  endtask

  // Acts as instruction memory for one fetch: waits for the request,
  // answers after `delay` extra WAIT cycles, then scoreboards the IR.
  task automatic fetch_one(input logic [15:0] word, input int delay, input bit drop_run);
    int n;
    logic [15:0] w;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (imem_req !== 1'b1) begin
      check("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    check("imem_addr", 32'(imem_addr), 32'(exp_pc));
    tick();
    check("req_one_cycle", 32'(imem_req), 32'd0);
    if (drop_run) run_en = 1'b0;
    repeat (delay) tick();
    imem_valid = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    tick();
    imem_valid = 1'b0;
    imem_rdata = 16'($urandom);
    check("ir_valid", 32'(ir_valid), 32'd1);
    check("state_hold", 32'(fetch_state), 32'(HOLD));
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("opcode_field", 32'(opcode_field), 32'(w[15:8]));
      check("imm_field", 32'(imm_field), 32'(w[7:0]));
    end
  endtask

  task automatic retire(input bit taken, input logic [7:0] off, input bit run);
    ex_ready  = 1'b1;
    br_taken  = taken;
    br_offset = off;
    run_en    = run;
    tick();
    ex_ready  = 1'b0;
    br_taken  = 1'($urandom_range(0, 1));
    br_offset = 8'($urandom_range(0, 255));
    exp_pc    = model_next(exp_pc, taken, off);
    check("pc_after_retire", 32'(pc), 32'(exp_pc));
    check("ir_valid_retired", 32'(ir_valid), 32'd0);
    check("req_after_retire", 32'(imem_req), 32'(run));
  endtask

  // Stimulus
  initial begin
    logic [15:0] w;
    rst_n      = 1'b0;
    run_en     = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    ex_ready   = 1'b0;
    br_taken   = 1'b0;
    br_offset  = 8'h00;
`ifdef I281_SINGLE_STEP_EN
    step       = 1'b0;
`endif
    repeat (3) tick();

    // Reset values
    check("rst_state", 32'(fetch_state), 32'(IDLE));
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_opcode", 32'(opcode_field), 32'd0);
    check("rst_imm", 32'(imm_field), 32'd0);
    rst_n = 1'b1;
    tick();

    // First fetch with exact latency: run_en in cycle 0, req in cycle 1,
    // data on the first WAIT cycle, ir_valid in cycle 3.
    run_en = 1'b1;
    tick();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_addr", 32'(imem_addr), 32'd0);
    check("c1_state", 32'(fetch_state), 32'(REQ));
    tick();
    check("c2_req", 32'(imem_req), 32'd0);
    check("c2_state", 32'(fetch_state), 32'(WAIT));
    check("c2_ir_valid", 32'(ir_valid), 32'd0);
    imem_valid = 1'b1;
    imem_rdata = 16'h5A03;
    exp_q.push_back(16'h5A03);
    tick();
    imem_valid = 1'b0;
    imem_rdata = 16'hFFFF;
    check("c3_ir_valid", 32'(ir_valid), 32'd1);
    w = exp_q.pop_front();
    check("c3_opcode", 32'(opcode_field), 32'(w[15:8]));
    check("c3_imm", 32'(imm_field), 32'(w[7:0]));

    // IR stays stable while not retired; no requests meanwhile.
    repeat (2) tick();
    check("hold_ir_valid", 32'(ir_valid), 32'd1);
    check("hold_opcode", 32'(opcode_field), 32'h5A);
    check("hold_no_req", 32'(imem_req), 32'd0);

    // Branch walk: 0 -> 10 -> 7 -> 10 -> 16 -> 63 -> 0 (wrap) -> 1
    retire(1'b1, 8'h09, 1'b1);
    fetch_one(16'($urandom), $urandom_range(0, 3), 1'b0);
    retire(1'b1, 8'hFC, 1'b1);
    fetch_one(16'($urandom), $urandom_range(0, 3), 1'b0);
    retire(1'b1, 8'h02, 1'b1);
    fetch_one(16'($urandom), $urandom_range(0, 3), 1'b0);
    retire(1'b1, 8'h05, 1'b1);
    fetch_one(16'($urandom), $urandom_range(0, 3), 1'b0);
    retire(1'b1, 8'h2E, 1'b1);
    fetch_one(16'($urandom), 14, 1'b0);
    retire(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    fetch_one(16'($urandom), $urandom_range(0, 3), 1'b0);
    retire(1'b1, 8'h80, 1'b1);

    // run_en dropped during WAIT: fetch completes, then unit stops.
    fetch_one(16'hC3A5, 2, 1'b1);
    retire(1'b0, 8'h00, 1'b0);
    repeat (5) begin
      tick();
      check("stopped_no_req", 32'(imem_req), 32'd0);
    end
    check("stopped_state", 32'(fetch_state), 32'(IDLE));

    // Reset in WAIT; a late imem_valid must be ignored.
    run_en = 1'b1;
    tick();
    check("rw_req", 32'(imem_req), 32'd1);
    tick();
    check("rw_state_wait", 32'(fetch_state), 32'(WAIT));
    rst_n = 1'b0;
    #1;
    check("rw_async_state", 32'(fetch_state), 32'(IDLE));
    check("rw_async_opcode", 32'(opcode_field), 32'd0);
    exp_pc = 0;
    tick();
    rst_n      = 1'b1;
    run_en     = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_valid = 1'b0;
    check("rw_ir_valid", 32'(ir_valid), 32'd0);
    check("rw_opcode", 32'(opcode_field), 32'd0);
    check("rw_imm", 32'(imm_field), 32'd0);
    check("rw_pc", 32'(pc), 32'd0);

    // WAIT timeout raises a sticky fault and blocks further requests.
    run_en = 1'b1;
    tick();
    check("to_req", 32'(imem_req), 32'd1);
    repeat (WAIT_MAX) tick();
    check("to_not_yet", 32'(fetch_fault), 32'd0);
    check("to_still_wait", 32'(fetch_state), 32'(WAIT));
    tick();
    check("to_fault", 32'(fetch_fault), 32'd1);
    check("to_state_idle", 32'(fetch_state), 32'(IDLE));
    check("to_ir_unchanged", 32'(opcode_field), 32'd0);
    check("to_ir_valid", 32'(ir_valid), 32'd0);
    repeat (8) begin
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = 16'($urandom);
      tick();
      check("fault_no_req", 32'(imem_req), 32'd0);
      check("fault_sticky", 32'(fetch_fault), 32'd1);
    end
    imem_valid = 1'b0;

    // Only reset clears the fault; fetching then resumes from 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("clr_fault", 32'(fetch_fault), 32'd0);
    exp_pc = 0;
    fetch_one(16'h1234, $urandom_range(0, 3), 1'b0);
    retire(1'b0, 8'h00, 1'b0);

    if (exp_q.size() != 0) check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
